// File: rtl/pwm_wavegen_pkg.sv
// Shared types and constants for the PWM waveform generator: FSM states,
// tick source encodings, register map and CTRL/STATUS bit positions.
package pwm_wavegen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TICK_MCLK,
    TICK_US,
    TICK_MS,
    TICK_NONE
  } tick_sel_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_HIGH   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_TSEL_LSB = 1;
  localparam int unsigned CTRL_ONE_SHOT = 3;
  localparam int unsigned CTRL_POLARITY = 4;
  localparam int unsigned CTRL_INTR_EN  = 5;
  localparam int unsigned CTRL_W        = 6;

  localparam int unsigned STAT_DONE = 16;
  localparam int unsigned STAT_INTR = 17;

  // True when the byte lane holding bit_idx is enabled for a write.
  function automatic logic be_hit(input logic [3:0] be, input int unsigned bit_idx);
    return be[bit_idx[4:3]];
  endfunction

endpackage

// File: rtl/pwm_wavegen_if.sv
// Register access bus of the PWM generator: strobe held until a one-cycle ack,
// read data valid together with the ack.
interface pwm_wavegen_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/pwm_wavegen_reg.sv
// Register file: CTRL/PERIOD/HIGH with byte-enable writes, STATUS with live
// counter and sticky done/intr (W1C on intr). CNT_W must not exceed 16.
module pwm_wavegen_reg
  import pwm_wavegen_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  pwm_wavegen_if.slave     bus,
  input  logic [CNT_W-1:0] counter,
  input  logic             set_intr,
  input  logic             set_done,
  input  logic             clr_done,
  output logic             enable,
  output tick_sel_e        tick_sel,
  output logic             one_shot,
  output logic             polarity,
  output logic             intr_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             done,
  output logic             intr
);

  logic [CTRL_W-1:0] ctrl;
  logic [CTRL_W-1:0] ctrl_nx;
  logic [CNT_W-1:0]  period_nx;
  logic [CNT_W-1:0]  high_nx;
  logic [31:0]       rd_mux;
  logic              wr_stb;
  logic              rd_stb;
  logic              w1c;

  assign enable   = ctrl[CTRL_ENABLE];
  assign tick_sel = tick_sel_e'(ctrl[CTRL_TSEL_LSB +: 2]);
  assign one_shot = ctrl[CTRL_ONE_SHOT];
  assign polarity = ctrl[CTRL_POLARITY];
  assign intr_en  = ctrl[CTRL_INTR_EN];

  // Writes land in the ack cycle; reads are captured on the cycle before it.
  assign wr_stb = bus.reg_cs & bus.reg_wr & bus.reg_ack;
  assign rd_stb = bus.reg_cs & ~bus.reg_wr & ~bus.reg_ack;
  assign w1c    = wr_stb && (bus.reg_addr == ADDR_STATUS) &&
                  be_hit(bus.reg_be, STAT_INTR) && bus.reg_wdata[STAT_INTR];

  always_comb begin
    ctrl_nx   = ctrl;
    period_nx = period;
    high_nx   = high;
    for (int unsigned i = 0; i < CTRL_W; i++) begin
      if (be_hit(bus.reg_be, i)) ctrl_nx[i] = bus.reg_wdata[i];
    end
    for (int unsigned i = 0; i < CNT_W; i++) begin
      if (be_hit(bus.reg_be, i)) begin
        period_nx[i] = bus.reg_wdata[i];
        high_nx[i]   = bus.reg_wdata[i];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      ADDR_CTRL:   rd_mux[CTRL_W-1:0] = ctrl;
      ADDR_PERIOD: rd_mux[CNT_W-1:0]  = period;
      ADDR_HIGH:   rd_mux[CNT_W-1:0]  = high;
      default: begin
        rd_mux[CNT_W-1:0] = counter;
        rd_mux[STAT_DONE] = done;
        rd_mux[STAT_INTR] = intr;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_ack   <= 1'b0;
      bus.reg_rdata <= '0;
      ctrl          <= '0;
      period        <= '0;
      high          <= '0;
      done          <= 1'b0;
      intr          <= 1'b0;
    end else begin
      bus.reg_ack <= bus.reg_cs & ~bus.reg_ack;
      if (rd_stb) bus.reg_rdata <= rd_mux;
      if (wr_stb) begin
        case (bus.reg_addr)
          ADDR_CTRL:   ctrl   <= ctrl_nx;
          ADDR_PERIOD: period <= period_nx;
          ADDR_HIGH:   high   <= high_nx;
          default:     ;
        endcase
      end
      // A period end in the same cycle as the W1C keeps intr set.
      intr <= set_intr | (intr & ~w1c);
      if (set_done)      done <= 1'b1;
      else if (clr_done) done <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_wavegen.sv
// PWM waveform generator core: IDLE/RUN/DONE sequencer, tick-gated period
// counter with shadowed PERIOD/HIGH, registered polarity-adjusted output.
module pwm_wavegen
  import pwm_wavegen_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic         mclk,
  input  logic         h_reset,
  input  logic         pulse_1us,
  input  logic         pulse_1ms,
  pwm_wavegen_if.slave bus,
  output logic         wave_out,
  output logic         wave_intr
);

  state_e           state;
  tick_sel_e        tick_sel;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] shadow_high;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             enable;
  logic             one_shot;
  logic             polarity;
  logic             intr_en;
  logic             done;
  logic             intr;
  logic             tick;
  logic             period_end;
  logic             set_intr;
  logic             set_done;
  logic             clr_done;

  pwm_wavegen_reg #(.CNT_W(CNT_W)) u_reg (
    .clk      (mclk),
    .rst      (h_reset),
    .bus      (bus),
    .counter  (counter),
    .set_intr (set_intr),
    .set_done (set_done),
    .clr_done (clr_done),
    .enable   (enable),
    .tick_sel (tick_sel),
    .one_shot (one_shot),
    .polarity (polarity),
    .intr_en  (intr_en),
    .period   (period),
    .high     (high),
    .done     (done),
    .intr     (intr)
  );

  always_comb begin
    tick = 1'b0;
    case (tick_sel)
      TICK_MCLK: tick = 1'b1;
      TICK_US:   tick = pulse_1us;
      TICK_MS:   tick = pulse_1ms;
      default:   tick = 1'b0;
    endcase
  end

  assign period_end = tick && (counter == shadow_period);
  assign set_intr   = (state == ST_RUN) && enable && period_end;
  assign set_done   = set_intr && one_shot;
  assign clr_done   = (state == ST_IDLE) && enable;
  assign wave_intr  = intr & intr_en;

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      state         <= ST_IDLE;
      counter       <= '0;
      shadow_period <= '0;
      shadow_high   <= '0;
      wave_out      <= 1'b0;
    end else begin
      wave_out <= ((state == ST_RUN) && (counter < shadow_high)) ^ polarity;
      case (state)
        ST_IDLE: begin
          counter <= '0;
          if (enable) begin
            shadow_period <= period;
            shadow_high   <= high;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state   <= ST_IDLE;
            counter <= '0;
          end else if (period_end) begin
            // New PERIOD/HIGH only take effect from a period boundary.
            counter       <= '0;
            shadow_period <= period;
            shadow_high   <= high;
            if (one_shot) state <= ST_DONE;
          end else if (tick) begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          counter <= '0;
          if (!enable) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pwm_wavegen.md
PWM_WAVEGEN -- requirements
Module: pwm_wavegen

Interface
REQ-001 Parameters: CNT_W, default 16, counter/period/compare width; SID_NONE: none other.
REQ-002 mclk  in  1  single block clock; all logic on rising edge.
REQ-003 h_reset  in  1  reset, asynchronous assert, active-high.
REQ-004 pulse_1us  in  1  one-mclk-wide 1 us tick from timer, mclk domain.
REQ-005 pulse_1ms  in  1  one-mclk-wide 1 ms tick from timer, mclk domain.
REQ-006 reg_cs  in  1  register access strobe, held until reg_ack.
REQ-007 reg_wr  in  1  1 = write, 0 = read.
REQ-008 reg_addr  in  2  word address: 0 CTRL, 1 PERIOD, 2 HIGH, 3 STATUS.
REQ-009 reg_wdata  in  32  write data.
REQ-010 reg_be  in  4  byte enables for writes.
REQ-011 reg_rdata  out  32  read data, valid with reg_ack.
REQ-012 reg_ack  out  1  one-cycle access acknowledge.
REQ-013 wave_out  out  1  generated waveform.
REQ-014 wave_intr  out  1  level interrupt = STATUS.intr & CTRL.intr_en.

Function
REQ-015 CTRL bits: [0] enable, [2:1] tick_sel (0 mclk, 1 pulse_1us, 2 pulse_1ms, 3 reserved = no tick), [3] one_shot, [4] polarity (1 = inverted output), [5] intr_en; others read 0.
REQ-016 PERIOD[CNT_W-1:0] and HIGH[CNT_W-1:0] are software registers; upper bits read 0.
REQ-017 STATUS read: [CNT_W-1:0] live counter, [16] done, [17] intr; write 1 to bit 17 clears intr, all other STATUS bits read-only.
REQ-018 Writes honour reg_be per byte; reg_ack asserts the cycle after reg_cs rises, for exactly one cycle (reg_ack <= reg_cs & ~reg_ack); a write commits in the ack cycle.
REQ-019 Tick = selected source per tick_sel; counter advances only on tick.
REQ-020 States: IDLE, RUN, DONE; encoded in package enum.
REQ-021 IDLE: counter 0, wave_out = polarity; enable 0->1 loads PERIOD/HIGH into shadow regs, goes RUN next cycle, clears done.
REQ-022 RUN: on tick, if counter == shadow_period then counter <= 0, set intr, reload shadows from PERIOD/HIGH; else counter <= counter + 1.
REQ-023 RUN, period end with one_shot = 1: go DONE, set done, counter holds 0.
REQ-024 DONE: wave_out = polarity; stays until enable written 0 (-> IDLE).
REQ-025 Waveform: raw = (counter < shadow_high) in RUN, 0 otherwise; wave_out = raw ^ polarity, registered (1 cycle after counter).
REQ-026 HIGH = 0: raw always 0; HIGH > PERIOD: raw always 1; PERIOD = 0: every tick is a period end.
REQ-027 PERIOD/HIGH writes during RUN affect output only after next period end (no glitch).
REQ-028 Counter never exceeds shadow_period; no overflow wrap beyond CNT_W.
REQ-029 enable written 0 in RUN or DONE: IDLE next cycle, counter 0, intr/done retained.
REQ-030 Same-cycle intr set and W1C: set wins.
REQ-031 tick_sel change during RUN takes effect next cycle; counter not reset.

Reset
REQ-032 On h_reset: all registers 0, state IDLE, counter 0, shadows 0, reg_ack 0, reg_rdata 0, wave_out 0, wave_intr 0.
REQ-033 Reset mid-RUN aborts immediately; outputs reach reset values asynchronously; operation resumes only after software re-enables.

Structure
REQ-034 Package pwm_wavegen_pkg holds state enum, register address constants, tick_sel encodings, CTRL bit positions.
REQ-035 One sub-module pwm_wavegen_reg: register file, byte-enable writes, ack, read mux, W1C; core FSM/counter in pwm_wavegen.

Verification
REQ-036 tick_sel=0, PERIOD=9, HIGH=3, enable -> wave_out high 3 of every 10 mclk, intr set every 10 cycles.
REQ-037 tick_sel=1, one_shot=1, PERIOD=4, HIGH=2, 1us ticks every 50 mclk -> one pulse of 100 mclk high, STATUS.done=1, state DONE, wave_out 0.
REQ-038 HIGH=0 then HIGH=20 with PERIOD=9, polarity=1 -> wave_out constant 1 then constant 0, changes only at period boundary.
REQ-039 Write HIGH=5 mid-period (PERIOD=9, HIGH=2) -> current period 2 high, next period 5 high.
REQ-040 intr pending, W1C to STATUS same cycle as period end -> intr remains 1; wave_intr follows intr_en.
REQ-041 Assert h_reset mid-RUN at counter=5 -> wave_out 0, counter 0, STATUS reads 0, no activity until enable rewritten.
